reg_file_sb: RTL



---
 rtl/reg_file_sb.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write bypass, pending-producer scoreboard and clear sweep
module reg_file_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [AW-1:0] Ard1,
  input  logic [AW-1:0] Ard2,
  output logic [DW-1:0] Dout1,
  output logic [DW-1:0] Dout2,
  input  logic [AW-1:0] Awr,
  input  logic [DW-1:0] Din,
  input  logic          WrEn,
  input  logic          Iss,
  input  logic [AW-1:0] Adst,
  output logic          Pend1,
  output logic          Pend2,
  input  logic          Clr,
  output logic          Busy
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] pend;

  logic idle;
  logic wr_ok;
  logic iss_ok;
  logic retire1;
  logic retire2;

  // Writes and issues are only honoured in IDLE; register 0 is read-only when hardwired
  assign idle    = (state == IDLE);
  assign wr_ok   = idle && WrEn && !(ZERO_REG && (Awr == '0));
  assign iss_ok  = Iss && !(ZERO_REG && (Adst == '0));
  // A retiring write to the read address hides its pend bit in the same cycle
  assign retire1 = idle && WrEn && (Awr == Ard1);
  assign retire2 = idle && WrEn && (Awr == Ard2);

  // Read port 1: array contents, forced zero for hardwired r0, overridden by same-cycle write
  always_comb begin
    Dout1 = regs[Ard1];
    if (ZERO_REG && (Ard1 == '0)) Dout1 = '0;
    if (wr_ok && (Awr == Ard1))   Dout1 = Din;
  end

  // Read port 2: same rules as port 1, bypass decided independently
  always_comb begin
    Dout2 = regs[Ard2];
    if (ZERO_REG && (Ard2 == '0)) Dout2 = '0;
    if (wr_ok && (Awr == Ard2))   Dout2 = Din;
  end

  // Pending flags seen by the reader, masked by a retiring write just like the data bypass
  always_comb begin
    Pend1 = pend[Ard1] && !retire1;
    Pend2 = pend[Ard2] && !retire2;
  end

  // Sweep FSM, register array and scoreboard; in CLEAR all external requests are ignored
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      pend  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        CLEAR: begin
          regs[cnt] <= '0;
          pend[cnt] <= 1'b0;
          if (cnt == LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          if (wr_ok)  regs[Awr] <= Din;
          // clear before set so a new producer issued on the retire edge stays pending
          if (WrEn)   pend[Awr] <= 1'b0;
          if (iss_ok) pend[Adst] <= 1'b1;
          if (Clr) begin
            state <= CLEAR;
            Busy  <= 1'b1;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule
